// File: rtl/ddr_cmd_pkg.sv
// rtl/ddr_cmd_pkg.sv - DDR4 command indices and RAS/CAS/WE truth-table encodings
package ddr_cmd_pkg;

  localparam int CMD_WIDTH = 19;

  // MPR and RSV occupy slots in the vector but no pin pattern asserts them
  typedef enum logic [4:0] {
    CMD_ACT    = 5'd0,
    CMD_PRE    = 5'd1,
    CMD_PREA   = 5'd2,
    CMD_RD     = 5'd3,
    CMD_RDA    = 5'd4,
    CMD_WR     = 5'd5,
    CMD_WRA    = 5'd6,
    CMD_REF    = 5'd7,
    CMD_SRE    = 5'd8,
    CMD_SRX    = 5'd9,
    CMD_PDE    = 5'd10,
    CMD_PDX    = 5'd11,
    CMD_MRS    = 5'd12,
    CMD_ZQCL   = 5'd13,
    CMD_ZQCS   = 5'd14,
    CMD_RD_BC4 = 5'd15,
    CMD_WR_BC4 = 5'd16,
    CMD_MPR    = 5'd17,
    CMD_RSV    = 5'd18
  } cmd_idx_e;

  localparam logic [2:0] ENC_MRS = 3'b000;
  localparam logic [2:0] ENC_REF = 3'b001;
  localparam logic [2:0] ENC_PRE = 3'b010;
  localparam logic [2:0] ENC_RSV = 3'b011;
  localparam logic [2:0] ENC_WR  = 3'b100;
  localparam logic [2:0] ENC_RD  = 3'b101;
  localparam logic [2:0] ENC_ZQ  = 3'b110;
  localparam logic [2:0] ENC_NOP = 3'b111;

endpackage

// File: rtl/ddr_bank_tracker.sv
// rtl/ddr_bank_tracker.sv - per-bank open flags and legality check for decoded commands
// Only instantiated when DDR_CMD_PROTOCOL_CHECK_EN is defined.
module ddr_bank_tracker
  import ddr_cmd_pkg::*;
#(
  parameter int NBANKS = 8,
  localparam int BIDXW = $clog2(NBANKS)
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  input  logic [CMD_WIDTH-1:0] cmd,
  input  logic [BIDXW-1:0]     bank_idx,
  output logic                 legal,
  output logic [NBANKS-1:0]    bank_open
);

  logic is_rw;
  logic bank_is_open;

  assign is_rw = cmd[CMD_RD] | cmd[CMD_RDA] | cmd[CMD_RD_BC4]
               | cmd[CMD_WR] | cmd[CMD_WRA] | cmd[CMD_WR_BC4];
  assign bank_is_open = bank_open[bank_idx];

  assign legal = !(cmd[CMD_ACT] && bank_is_open)
              && !(is_rw && !bank_is_open)
              && !((cmd[CMD_REF] || cmd[CMD_SRE]) && (|bank_open));

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_open <= '0;
    end else if (!halt && legal) begin
      if (cmd[CMD_ACT])
        bank_open[bank_idx] <= 1'b1;
      if (cmd[CMD_PRE] || cmd[CMD_RDA] || cmd[CMD_WRA])
        bank_open[bank_idx] <= 1'b0;
      if (cmd[CMD_PREA])
        bank_open <= '0;
    end
  end

endmodule

// File: rtl/ddr_cmd_decoder.sv
// rtl/ddr_cmd_decoder.sv - DDR4 command/address pin decoder with registered one-hot output
// Bank tracking and illegal-command dropping exist only with DDR_CMD_PROTOCOL_CHECK_EN.
module ddr_cmd_decoder
  import ddr_cmd_pkg::*;
#(
  parameter int ADDRWIDTH     = 17,
  parameter int BANKGROUPS    = 4,
  parameter int BANKSPERGROUP = 2,
  parameter int COLS          = 1024,
  localparam int BGWIDTH      = $clog2(BANKGROUPS),
  localparam int BAWIDTH      = $clog2(BANKSPERGROUP),
  localparam int CADDRWIDTH   = $clog2(COLS),
  localparam int NBANKS       = BANKGROUPS * BANKSPERGROUP
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  input  logic                  cke,
  input  logic                  cs_n,
  input  logic                  act_n,
  input  logic                  ras_n_a16,
  input  logic                  cas_n_a15,
  input  logic                  we_n_a14,
  input  logic [BGWIDTH-1:0]    bg_in,
  input  logic [BAWIDTH:0]      ba_in,
  input  logic [13:0]           a,
  output logic [CMD_WIDTH-1:0]  commands,
  output logic [BGWIDTH-1:0]    bg,
  output logic [BAWIDTH:0]      ba,
  output logic [ADDRWIDTH-1:0]  row,
  output logic [CADDRWIDTH-1:0] column,
  output logic [NBANKS-1:0]     bank_open,
  output logic                  err,
  output logic [15:0]           err_count
);

  logic                 cke_q;
  logic                 self_refresh;
  logic                 legal;
  logic                 nop_or_des;
  logic                 is_rw;
  logic [2:0]           enc;
  logic [16:0]          row_full;
  logic [CMD_WIDTH-1:0] dec;

  assign enc        = {ras_n_a16, cas_n_a15, we_n_a14};
  assign nop_or_des = cs_n || (act_n && enc == ENC_NOP);
  assign row_full   = {ras_n_a16, cas_n_a15, we_n_a14, a};
  assign is_rw      = dec[CMD_RD] | dec[CMD_RDA] | dec[CMD_RD_BC4]
                    | dec[CMD_WR] | dec[CMD_WRA] | dec[CMD_WR_BC4];

  // cke edges take precedence over the pin command; cke low on both cycles decodes nothing
  always_comb begin
    dec = '0;
    if (!cke_q && cke) begin
      if (nop_or_des)
        dec[self_refresh ? CMD_SRX : CMD_PDX] = 1'b1;
    end else if (cke_q && !cke) begin
      if (nop_or_des)
        dec[CMD_PDE] = 1'b1;
      else if (act_n && enc == ENC_REF)
        dec[CMD_SRE] = 1'b1;
    end else if (cke_q && cke && !cs_n) begin
      if (!act_n) begin
        dec[CMD_ACT] = 1'b1;
      end else begin
        case (enc)
          ENC_MRS: dec[CMD_MRS] = 1'b1;
          ENC_REF: dec[CMD_REF] = 1'b1;
          ENC_PRE: dec[a[10] ? CMD_PREA : CMD_PRE] = 1'b1;
          ENC_WR:  dec[a[10] ? CMD_WRA : (a[12] ? CMD_WR : CMD_WR_BC4)] = 1'b1;
          ENC_RD:  dec[a[10] ? CMD_RDA : (a[12] ? CMD_RD : CMD_RD_BC4)] = 1'b1;
          ENC_ZQ:  dec[a[10] ? CMD_ZQCL : CMD_ZQCS] = 1'b1;
          ENC_RSV, ENC_NOP: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commands     <= '0;
      bg           <= '0;
      ba           <= '0;
      row          <= '0;
      column       <= '0;
      cke_q        <= 1'b0;
      self_refresh <= 1'b0;
    end else if (halt) begin
      commands <= '0;
    end else begin
      cke_q    <= cke;
      commands <= legal ? dec : '0;
      if (legal && (|dec)) begin
        bg <= bg_in;
        ba <= ba_in;
      end
      if (legal && dec[CMD_ACT])
        row <= row_full[ADDRWIDTH-1:0];
      if (legal && is_rw)
        column <= a[CADDRWIDTH-1:0];
      if (legal && dec[CMD_SRE])
        self_refresh <= 1'b1;
      else if (dec[CMD_SRX])
        self_refresh <= 1'b0;
    end
  end

`ifdef DDR_CMD_PROTOCOL_CHECK_EN
  localparam int BIDXW = $clog2(NBANKS);

  logic [BIDXW-1:0] bank_idx;
  logic             err_q;
  logic [15:0]      err_count_q;

  assign bank_idx = BIDXW'(int'(bg_in) * BANKSPERGROUP + int'(ba_in[BAWIDTH-1:0]));

  ddr_bank_tracker #(.NBANKS(NBANKS)) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .halt      (halt),
    .cmd       (dec),
    .bank_idx  (bank_idx),
    .legal     (legal),
    .bank_open (bank_open)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else if (halt) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (|dec) && !legal;
      if ((|dec) && !legal && err_count_q != 16'hFFFF)
        err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err       = err_q;
  assign err_count = err_count_q;
`else
  assign legal     = 1'b1;
  assign bank_open = '0;
  assign err       = 1'b0;
  assign err_count = '0;
`endif

endmodule
